// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner: prescaled digit rotation, anti-ghost
// blanking, tear-free double-buffered display data and leading-zero suppression.
module seven_seg_scan #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned CLK_DIV    = 50000,
    parameter int unsigned BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PrescLast = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] BlankEnd  = PW'(BLANK_CYC);
    localparam logic [IW-1:0] IdxLast   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0] presc_q;
    logic [IW-1:0] idx_q;
    logic          presc_wrap;
    logic          frame_wrap;

    // Shadow holds the most recent load until the frame boundary; active drives the display.
    logic [4*NUM_DIGITS-1:0] shadow_hex_q, active_hex_q;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, active_dp_q;
    logic [NUM_DIGITS-1:0]   shadow_blank_q, active_blank_q;
    logic                    pending_q;

    logic [NUM_DIGITS-1:0]   dark;
    logic [6:0]              seg_d;
    logic                    dp_d;
    logic [NUM_DIGITS-1:0]   an_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        s = 7'b0000000;
        case (h)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            4'hF: s = 7'b1000111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign presc_wrap = (presc_q == PrescLast);
    assign frame_wrap = presc_wrap && (idx_q == IdxLast);

    // Prescaler and digit index; the index steps once per slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (presc_wrap) begin
            presc_q <= '0;
            idx_q   <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Double buffer: loads land in shadow, promoted to active only at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_hex_q   <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '0;
            active_hex_q   <= '0;
            active_dp_q    <= '0;
            active_blank_q <= '0;
            pending_q      <= 1'b0;
        end else if (frame_wrap && load) begin
            // A load on the boundary cycle bypasses the shadow.
            active_hex_q   <= hex_in;
            active_dp_q    <= dp_in;
            active_blank_q <= blank_in;
            pending_q      <= 1'b0;
        end else if (load) begin
            shadow_hex_q   <= hex_in;
            shadow_dp_q    <= dp_in;
            shadow_blank_q <= blank_in;
            pending_q      <= 1'b1;
        end else if (frame_wrap && pending_q) begin
            active_hex_q   <= shadow_hex_q;
            active_dp_q    <= shadow_dp_q;
            active_blank_q <= shadow_blank_q;
            pending_q      <= 1'b0;
        end
    end

    // Per-digit darkening: forced blank, or a leading zero with no decimal point.
    always_comb begin : dark_calc
        logic upper_zero;
        upper_zero = 1'b1;
        dark       = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (active_hex_q[4*k +: 4] == 4'h0);
            dark[k]    = active_blank_q[k] ||
                         (lz_en && (k != 0) && upper_zero && !active_dp_q[k]);
        end
    end

    // Next output values, derived from current-cycle state.
    always_comb begin
        seg_d = '0;
        dp_d  = 1'b0;
        an_d  = '0;
        if (presc_q >= BlankEnd) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_q == IW'(k)) begin
                    an_d[k] = 1'b1;
                    if (!dark[k]) begin
                        seg_d = hex_to_seg(active_hex_q[4*k +: 4]);
                        dp_d  = active_dp_q[k];
                    end
                end
            end
        end
    end

    // Output registers; frame_done marks the first cycle of a new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= '0;
            dp         <= 1'b0;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_d;
            dp         <= dp_d;
            an         <= an_d;
            frame_done <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: directed scenarios plus random loads,
// compared each cycle against a time-indexed reference model.
module tb_seven_seg_scan;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int BLK   = 1;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] hex_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        lz_en = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    typedef struct {
        int          frame;
        logic [15:0] hex;
        logic [3:0]  dpv;
        logic [3:0]  blk;
    } load_t;

    load_t      loads[$];
    int         cyc;
    int         n_checks;
    int         n_errors;
    logic       prev_lz;
    logic [6:0] seg_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    seven_seg_scan #(
        .NUM_DIGITS (N),
        .CLK_DIV    (DIV),
        .BLANK_CYC  (BLK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .lz_en      (lz_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Outputs seen in cycle cyc reflect the state of cycle cyc-1. Data loaded in
    // frame F is displayed from frame F+1 onward (latest load wins).
    task automatic check_outputs();
        int          n;
        int          pos;
        int          d;
        int          fr;
        logic [15:0] h;
        logic [3:0]  dv;
        logic [3:0]  bv;
        logic [3:0]  nib;
        logic [6:0]  es;
        logic        ed;
        logic [3:0]  ea;
        logic        ef;
        logic        supp;
        n   = cyc - 1;
        pos = n % DIV;
        d   = (n / DIV) % N;
        fr  = n / FRAME;
        h   = '0;
        dv  = '0;
        bv  = '0;
        foreach (loads[i]) begin
            if (loads[i].frame < fr) begin
                h  = loads[i].hex;
                dv = loads[i].dpv;
                bv = loads[i].blk;
            end
        end
        es  = '0;
        ed  = 1'b0;
        ea  = '0;
        ef  = ((n % FRAME) == FRAME - 1);
        nib = 4'((h >> (4 * d)) & 16'hF);
        supp = prev_lz && (d > 0) && !dv[d] && ((h >> (4 * d)) == 16'h0);
        if (pos >= BLK) begin
            ea = 4'(1 << d);
            if (!bv[d] && !supp) begin
                es = seg_tab[nib];
                ed = dv[d];
            end
        end
        check_val("seg", 16'(seg), 16'(es));
        check_val("dp", 16'(dp), 16'(ed));
        check_val("an", 16'(an), 16'(ea));
        check_val("frame_done", 16'(frame_done), 16'(ef));
    endtask

    // Called at a falling edge with inputs already set for cycle cyc.
    task automatic tick();
        if (load) loads.push_back('{cyc / FRAME, hex_in, dp_in, blank_in});
        prev_lz = lz_en;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input logic [15:0] h, input logic [3:0] dv, input logic [3:0] bv);
        load     = 1'b1;
        hex_in   = h;
        dp_in    = dv;
        blank_in = bv;
    endtask

    // Non-load cycles carry random data that must be ignored.
    task automatic idle();
        load     = 1'b0;
        hex_in   = 16'($urandom);
        dp_in    = 4'($urandom);
        blank_in = 4'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_seg"}, 16'(seg), 16'h0);
        check_val({tag, "_dp"}, 16'(dp), 16'h0);
        check_val({tag, "_an"}, 16'(an), 16'h0);
        check_val({tag, "_fd"}, 16'(frame_done), 16'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        prev_lz  = 1'b0;

        // Power-on reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        cyc   = 0;
        loads.delete();

        // Load 1234 in the first cycle after release
        lz_en = 1'b0;
        drive(16'h1234, 4'b0000, 4'b0000);
        tick();
        idle();
        repeat (2 * FRAME) tick();

        // Mid-frame load of ABCD
        while (cyc % FRAME != 6) tick();
        drive(16'hABCD, 4'b0000, 4'b0000);
        tick();
        idle();
        repeat (2 * FRAME) tick();

        // Two loads in one frame: last wins
        while (cyc % FRAME != 2) tick();
        drive(16'h1111, 4'b0000, 4'b0000);
        tick();
        idle();
        repeat (3) tick();
        drive(16'h2222, 4'b0000, 4'b0000);
        tick();
        idle();
        repeat (2 * FRAME) tick();

        // Load on the boundary cycle with leading-zero suppression
        lz_en = 1'b1;
        while (cyc % FRAME != FRAME - 1) tick();
        drive(16'h00F0, 4'b0000, 4'b0000);
        tick();
        idle();
        repeat (FRAME + 2) tick();

        // Forced blank and decimal point
        lz_en = 1'b0;
        drive(16'h5678, 4'b0001, 4'b0100);
        tick();
        idle();
        repeat (2 * FRAME) tick();

        // Random loads with live lz_en toggling
        repeat (400) begin
            load     = ($urandom_range(0, 7) == 0);
            hex_in   = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp_in    = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0000;
            blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            lz_en    = 1'($urandom);
            tick();
        end

        // Asynchronous reset in the middle of a slot
        load = 1'b0;
        while (cyc % DIV != 2) tick();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_hold");
        rst_n = 1'b1;
        cyc   = 0;
        loads.delete();
        idle();
        repeat (FRAME) begin
            lz_en = 1'b0;
            tick();
        end
        repeat (FRAME) begin
            lz_en = 1'b1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
